// File: rtl/ece453_gpio_irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ece453_gpio_irq_ctrl_pkg
// Purpose : Shared register map, CONTROL bit positions and helpers for the
//           GPIO interrupt controller.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package ece453_gpio_irq_ctrl_pkg;

  // Word addresses of the register map
  localparam logic [4:0] ADDR_DEV_ID    = 5'd0;
  localparam logic [4:0] ADDR_CONTROL   = 5'd1;
  localparam logic [4:0] ADDR_RAW       = 5'd2;
  localparam logic [4:0] ADDR_DEBOUNCED = 5'd3;
  localparam logic [4:0] ADDR_RISE_EN   = 5'd4;
  localparam logic [4:0] ADDR_FALL_EN   = 5'd5;
  localparam logic [4:0] ADDR_IM        = 5'd6;
  localparam logic [4:0] ADDR_IRQ       = 5'd7;
  localparam logic [4:0] ADDR_EDGE_CNT  = 5'd8;

  // CONTROL register bits
  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_CLR_ALL_BIT = 1;

  // Width of the saturating event counter
  localparam int EDGE_CNT_W = 16;

  // Expand the four Avalon byte enables to a per-bit write mask
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ece453_gpio_irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : ece453_gpio_irq_ctrl_if
// Purpose : Avalon-MM slave bus bundle for the GPIO interrupt controller.
// Signals : slave_address(5) slave_read slave_write slave_writedata(32)
//           slave_byteenable(4) slave_readdata(32, combinational)
// Rev     : 1.0  initial release
// ============================================================================
interface ece453_gpio_irq_ctrl_if;
  logic [4:0]  slave_address;
  logic        slave_read;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic [3:0]  slave_byteenable;
  logic [31:0] slave_readdata;

  modport master (
    output slave_address, slave_read, slave_write, slave_writedata, slave_byteenable,
    input  slave_readdata
  );

  modport slave (
    input  slave_address, slave_read, slave_write, slave_writedata, slave_byteenable,
    output slave_readdata
  );
endinterface
`default_nettype wire

// File: rtl/ece453_gpio_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module  : ece453_gpio_debounce_ch
// Purpose : One GPIO channel: 2-flop synchroniser, tick-sampled stability
//           counter, debounced level and a one-cycle change pulse.
// Ports   : clk, reset (async, active-high)
//           i_raw     asynchronous pin
//           i_tick    shared prescaled sample strobe
//           i_enable  debounce enable; when low the counter is held at 0
//           o_sync    synchronised pin level
//           o_db      debounced level
//           o_pulse   high for one cycle, aligned with the o_db update
// Rev     : 1.0  initial release
// ============================================================================
module ece453_gpio_debounce_ch #(
  parameter int STABLE_CNT = 8
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  i_raw,
  input  wire  i_tick,
  input  wire  i_enable,
  output logic o_sync,
  output logic o_db,
  output logic o_pulse
);

  localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_db;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_db    <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta  <= i_raw;
      r_sync  <= r_meta;
      r_pulse <= 1'b0;
      if (!i_enable) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (r_sync == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == C_CNT_LAST) begin
          // Enough consecutive disagreeing samples: accept the new level
          r_db    <= r_sync;
          r_cnt   <= '0;
          r_pulse <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_sync  = r_sync;
  assign o_db    = r_db;
  assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/ece453_gpio_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ece453_gpio_irq_ctrl
// Purpose : Multi-channel debounced GPIO input block with edge detection,
//           sticky W1C interrupt status, mask and saturating event counter,
//           accessed over an Avalon-MM slave.
// Ports   : clk, reset (async, active-high)
//           bus       Avalon-MM slave (address/read/write/writedata/
//                     byteenable/readdata)
//           gpio_raw  asynchronous inputs [NUM_CH]
//           gpio_db   debounced levels   [NUM_CH]
//           irq_out   level interrupt, OR of masked pending bits
// Rev     : 1.0  initial release
// ============================================================================
module ece453_gpio_irq_ctrl
  import ece453_gpio_irq_ctrl_pkg::*;
#(
  parameter int          NUM_CH     = 8,
  parameter int          TICK_DIV   = 500000,
  parameter int          STABLE_CNT = 8,
  parameter logic [31:0] DEV_ID     = 32'hECE45320
) (
  input  wire                       clk,
  input  wire                       reset,
  ece453_gpio_irq_ctrl_if.slave     bus,
  input  wire  [NUM_CH-1:0]         gpio_raw,
  output logic [NUM_CH-1:0]         gpio_db,
  output logic                      irq_out
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0]     r_tick_cnt;
  logic                  r_enable;
  logic [NUM_CH-1:0]     r_rise_en;
  logic [NUM_CH-1:0]     r_fall_en;
  logic [NUM_CH-1:0]     r_im;
  logic [NUM_CH-1:0]     r_irq;
  logic [EDGE_CNT_W-1:0] r_edge_cnt;

  logic                  w_tick;
  logic [NUM_CH-1:0]     w_sync;
  logic [NUM_CH-1:0]     w_db;
  logic [NUM_CH-1:0]     w_pulse;
  logic [NUM_CH-1:0]     w_event;
  logic                  w_any_event;
  logic [31:0]           w_be_bits;
  logic [NUM_CH-1:0]     w_bm;
  logic [NUM_CH-1:0]     w_wd;
  logic                  w_wr_ctrl;
  logic                  w_wr_rise;
  logic                  w_wr_fall;
  logic                  w_wr_im;
  logic                  w_wr_irq;
  logic                  w_clr_all;
  logic [NUM_CH-1:0]     w_w1c;
  logic [31:0]           w_rdata;
  logic                  w_unused_bits;

  assign w_tick = (r_tick_cnt == C_TICK_LAST);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ece453_gpio_debounce_ch #(
        .STABLE_CNT (STABLE_CNT)
      ) u_db (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (gpio_raw[gi]),
        .i_tick   (w_tick),
        .i_enable (r_enable),
        .o_sync   (w_sync[gi]),
        .o_db     (w_db[gi]),
        .o_pulse  (w_pulse[gi])
      );
      // o_db already holds the new level while the pulse is high
      assign w_event[gi] = r_enable & w_pulse[gi] &
                           (w_db[gi] ? r_rise_en[gi] : r_fall_en[gi]);
    end
  endgenerate

  assign w_any_event = |w_event;

  // Bus write decode
  assign w_be_bits = byte_mask(bus.slave_byteenable);
  assign w_bm      = w_be_bits[NUM_CH-1:0];
  assign w_wd      = bus.slave_writedata[NUM_CH-1:0];
  assign w_wr_ctrl = bus.slave_write && (bus.slave_address == ADDR_CONTROL) &&
                     bus.slave_byteenable[0];
  assign w_wr_rise = bus.slave_write && (bus.slave_address == ADDR_RISE_EN);
  assign w_wr_fall = bus.slave_write && (bus.slave_address == ADDR_FALL_EN);
  assign w_wr_im   = bus.slave_write && (bus.slave_address == ADDR_IM);
  assign w_wr_irq  = bus.slave_write && (bus.slave_address == ADDR_IRQ);
  assign w_clr_all = w_wr_ctrl && bus.slave_writedata[CTRL_CLR_ALL_BIT];
  assign w_w1c     = w_wr_irq ? (w_wd & w_bm) : '0;

  // Collects bits that are intentionally not consumed for small NUM_CH
  assign w_unused_bits = ^{bus.slave_writedata, w_be_bits};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_enable   <= 1'b0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_im       <= '0;
      r_irq      <= '0;
      r_edge_cnt <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;

      if (w_wr_ctrl) r_enable <= bus.slave_writedata[CTRL_ENABLE_BIT];
      if (w_wr_rise) r_rise_en <= (r_rise_en & ~w_bm) | (w_wd & w_bm);
      if (w_wr_fall) r_fall_en <= (r_fall_en & ~w_bm) | (w_wd & w_bm);
      if (w_wr_im)   r_im      <= (r_im      & ~w_bm) | (w_wd & w_bm);

      // Clears first, then new events OR in so a coincident event wins
      r_irq <= (r_irq & ~w_w1c & {NUM_CH{~w_clr_all}}) | w_event;

      if (w_clr_all) begin
        r_edge_cnt <= EDGE_CNT_W'(w_any_event);
      end else if (w_any_event && (r_edge_cnt != '1)) begin
        r_edge_cnt <= r_edge_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (bus.slave_read) begin
      case (bus.slave_address)
        ADDR_DEV_ID:    w_rdata = DEV_ID;
        ADDR_CONTROL:   w_rdata[CTRL_ENABLE_BIT] = r_enable;
        ADDR_RAW:       w_rdata[NUM_CH-1:0] = w_sync;
        ADDR_DEBOUNCED: w_rdata[NUM_CH-1:0] = w_db;
        ADDR_RISE_EN:   w_rdata[NUM_CH-1:0] = r_rise_en;
        ADDR_FALL_EN:   w_rdata[NUM_CH-1:0] = r_fall_en;
        ADDR_IM:        w_rdata[NUM_CH-1:0] = r_im;
        ADDR_IRQ:       w_rdata[NUM_CH-1:0] = r_irq;
        ADDR_EDGE_CNT:  w_rdata[EDGE_CNT_W-1:0] = r_edge_cnt;
        default:        w_rdata = '0;
      endcase
    end
  end

  assign bus.slave_readdata = w_rdata;
  assign gpio_db            = w_db;
  assign irq_out            = |(r_irq & r_im);

endmodule
`default_nettype wire

// File: tb/tb_ece453_gpio_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ece453_gpio_irq_ctrl
// Purpose : Self-checking bench for ece453_gpio_irq_ctrl (NUM_CH=4,
//           TICK_DIV=4, STABLE_CNT=3).
// Rev     : 1.0  initial release
// ============================================================================
module tb_ece453_gpio_irq_ctrl;

  localparam int NUM_CH = 4;

  logic              clk;
  logic              reset;
  logic [NUM_CH-1:0] gpio_raw;
  logic [NUM_CH-1:0] gpio_db;
  logic              irq_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] rd;
  logic [31:0] exp;

  ece453_gpio_irq_ctrl_if bus ();

  ece453_gpio_irq_ctrl #(
    .NUM_CH     (NUM_CH),
    .TICK_DIV   (4),
    .STABLE_CNT (3),
    .DEV_ID     (32'hECE45320)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .gpio_raw (gpio_raw),
    .gpio_db  (gpio_db),
    .irq_out  (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.slave_address    = a;
    bus.slave_writedata  = d;
    bus.slave_byteenable = be;
    bus.slave_write      = 1'b1;
    @(posedge clk);
    #1;
    bus.slave_write      = 1'b0;
    bus.slave_byteenable = 4'h0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.slave_address = a;
    bus.slave_read    = 1'b1;
    #1;
    d = bus.slave_readdata;
    @(posedge clk);
    #1;
    bus.slave_read = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Waits for gpio_db[ch]==v, bounded by budget cycles
  task automatic wait_db(input int ch, input logic v, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (gpio_db[ch] === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(3);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(32'hECE45320);
    for (int a = 1; a <= 8; a++) exp_q.push_back(32'h0);
    for (int a = 0; a <= 8; a++) begin
      bus_read(a[4:0], rd);
      exp = exp_q.pop_front();
      n_checks++;
      if (rd !== exp) begin
        n_fail++;
        $display("FAIL reset_read addr %0d: got %h expected %h", a, rd, exp);
      end
    end
    n_checks++;
    if (irq_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq_out: got %b expected 0", irq_out);
    end
  endtask

  task automatic test_rise();
    bit ok;
    bus_write(5'd1, 32'h1, 4'hF);
    bus_write(5'd4, 32'h1, 4'hF);
    bus_write(5'd6, 32'h1, 4'hF);
    @(negedge clk);
    gpio_raw[0] = 1'b1;
    wait_db(0, 1'b1, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rise_db_timeout: gpio_db=%b expected bit0=1", gpio_db);
    end
    wait_cycles(2);
    exp_q.push_back(32'h1);  // DEBOUNCED
    exp_q.push_back(32'h1);  // IRQ
    exp_q.push_back(32'h1);  // EDGE_CNT
    bus_read(5'd3, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL rise_debounced: got %h expected %h", rd, exp); end
    bus_read(5'd7, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL rise_irq: got %h expected %h", rd, exp); end
    bus_read(5'd8, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL rise_edge_cnt: got %h expected %h", rd, exp); end
    n_checks++;
    if (irq_out !== 1'b1) begin n_fail++; $display("FAIL rise_irq_out: got %b expected 1", irq_out); end
  endtask

  task automatic test_glitch();
    bit seen;
    bus_write(5'd4, 32'hF, 4'hF);
    bus_write(5'd5, 32'hF, 4'hF);
    seen = 1'b0;
    @(negedge clk);
    gpio_raw[1] = 1'b1;
    // Seven clocks high spans at most two sample ticks
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (gpio_db[1] !== 1'b0) seen = 1'b1;
    end
    gpio_raw[1] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gpio_db[1] !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL glitch_db1: got 1 expected 0"); end
    exp_q.push_back(32'h1);  // DEBOUNCED
    exp_q.push_back(32'h1);  // IRQ
    bus_read(5'd3, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL glitch_debounced: got %h expected %h", rd, exp); end
    bus_read(5'd7, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL glitch_irq: got %h expected %h", rd, exp); end
  endtask

  task automatic test_w1c_collision();
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    gpio_raw[0] = 1'b0;
    // On the first negedge showing the fall, the event is pending for the
    // coming edge; issue the W1C so both land together.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gpio_db[0] === 1'b0) begin
        ok = 1'b1;
        bus.slave_address    = 5'd7;
        bus.slave_writedata  = 32'h1;
        bus.slave_byteenable = 4'hF;
        bus.slave_write      = 1'b1;
        @(posedge clk);
        #1;
        bus.slave_write      = 1'b0;
        bus.slave_byteenable = 4'h0;
        break;
      end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL collide_db_timeout: gpio_db=%b expected bit0=0", gpio_db); end
    exp_q.push_back(32'h1);  // IRQ survives
    exp_q.push_back(32'h2);  // EDGE_CNT
    bus_read(5'd7, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL collide_irq: got %h expected %h", rd, exp); end
    bus_read(5'd8, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL collide_edge_cnt: got %h expected %h", rd, exp); end
    // No byte lanes: nothing cleared
    bus_write(5'd7, 32'h1, 4'h0);
    exp_q.push_back(32'h1);
    bus_read(5'd7, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL w1c_no_lane: got %h expected %h", rd, exp); end
    bus_write(5'd7, 32'h1, 4'hF);
    exp_q.push_back(32'h0);
    bus_read(5'd7, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL w1c_clear: got %h expected %h", rd, exp); end
    n_checks++;
    if (irq_out !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_out: got %b expected 0", irq_out); end
  endtask

  task automatic test_mask_clr_all();
    bit ok;
    @(negedge clk);
    gpio_raw[1:0] = 2'b11;
    wait_db(1, 1'b1, 40, ok);
    n_checks++;
    if (!ok || gpio_db[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mask_db_timeout: gpio_db=%b expected xx11", gpio_db);
    end
    wait_cycles(2);
    exp_q.push_back(32'h3);  // IRQ
    exp_q.push_back(32'h3);  // EDGE_CNT: both edges in one cycle
    bus_read(5'd7, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL mask_irq: got %h expected %h", rd, exp); end
    bus_read(5'd8, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL mask_edge_cnt: got %h expected %h", rd, exp); end
    bus_write(5'd6, 32'h0, 4'hF);
    #1;
    n_checks++;
    if (irq_out !== 1'b0) begin n_fail++; $display("FAIL mask_im0_irq_out: got %b expected 0", irq_out); end
    // Write to IM with lane 0 disabled must not change it
    bus_write(5'd6, 32'hF, 4'hE);
    exp_q.push_back(32'h0);
    bus_read(5'd6, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL im_byte_lane: got %h expected %h", rd, exp); end
    bus_write(5'd6, 32'h2, 4'hF);
    #1;
    n_checks++;
    if (irq_out !== 1'b1) begin n_fail++; $display("FAIL mask_im2_irq_out: got %b expected 1", irq_out); end
    bus_write(5'd1, 32'h3, 4'hF);
    exp_q.push_back(32'h0);  // IRQ
    exp_q.push_back(32'h0);  // EDGE_CNT
    exp_q.push_back(32'h1);  // CONTROL, CLR_ALL reads 0
    bus_read(5'd7, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL clr_all_irq: got %h expected %h", rd, exp); end
    bus_read(5'd8, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL clr_all_edge_cnt: got %h expected %h", rd, exp); end
    bus_read(5'd1, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL clr_all_control: got %h expected %h", rd, exp); end
    n_checks++;
    if (irq_out !== 1'b0) begin n_fail++; $display("FAIL clr_all_irq_out: got %b expected 0", irq_out); end
  endtask

  task automatic test_disable_reset();
    bus_write(5'd1, 32'h0, 4'hF);
    @(negedge clk);
    gpio_raw = 4'b1100;
    wait_cycles(3);
    exp_q.push_back(32'hC);  // RAW
    bus_read(5'd2, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL dis_raw: got %h expected %h", rd, exp); end
    wait_cycles(30);
    exp_q.push_back(32'h3);  // DEBOUNCED frozen
    exp_q.push_back(32'h0);  // IRQ
    exp_q.push_back(32'h0);  // EDGE_CNT
    bus_read(5'd3, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL dis_debounced: got %h expected %h", rd, exp); end
    bus_read(5'd7, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL dis_irq: got %h expected %h", rd, exp); end
    bus_read(5'd8, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL dis_edge_cnt: got %h expected %h", rd, exp); end
    // Re-enable so counters start running, then reset between edges
    bus_write(5'd1, 32'h1, 4'hF);
    wait_cycles(6);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (gpio_db !== 4'h0) begin n_fail++; $display("FAIL async_reset_db: got %b expected 0000", gpio_db); end
    n_checks++;
    if (irq_out !== 1'b0) begin n_fail++; $display("FAIL async_reset_irq_out: got %b expected 0", irq_out); end
    gpio_raw = 4'h0;
    wait_cycles(3);
    @(negedge clk);
    reset = 1'b0;
    wait_cycles(3);
    exp_q.push_back(32'hECE45320);
    for (int a = 1; a <= 8; a++) exp_q.push_back(32'h0);
    for (int a = 0; a <= 8; a++) begin
      bus_read(a[4:0], rd);
      exp = exp_q.pop_front();
      n_checks++;
      if (rd !== exp) begin
        n_fail++;
        $display("FAIL post_reset_read addr %0d: got %h expected %h", a, rd, exp);
      end
    end
  endtask

  initial begin
    reset                = 1'b1;
    gpio_raw             = '0;
    bus.slave_address    = '0;
    bus.slave_read       = 1'b0;
    bus.slave_write      = 1'b0;
    bus.slave_writedata  = '0;
    bus.slave_byteenable = '0;
    test_reset();
    test_rise();
    test_glitch();
    test_w1c_collision();
    test_mask_clr_all();
    test_disable_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
